// File: rtl/snake_score_if.sv
// Game-logic to score-keeper bus: eat/game-over/restart events in, BCD score and record status out.
interface snake_score_if;
    logic        eat;
    logic        game_over;
    logic        restart;
    logic [3:0]  score_data;
    logic [3:0]  score_tens;
    logic [3:0]  score_hund;
    logic [11:0] hi_score;
    logic        new_record;
    logic        saturated;

    modport master (
        output eat, game_over, restart,
        input  score_data, score_tens, score_hund, hi_score, new_record, saturated
    );

    modport slave (
        input  eat, game_over, restart,
        output score_data, score_tens, score_hund, hi_score, new_record, saturated
    );
endinterface

// File: rtl/snake_score_keeper.sv
// Saturating 3-digit BCD score counter for the snake game, with session high score
// and new-record flag; units digit feeds the seven-segment tube driver.
module snake_score_keeper #(
    parameter int unsigned POINTS_PER_EAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    snake_score_if.slave  bus
);

    localparam int unsigned DIG_W   = 4;
    localparam int unsigned SCORE_W = 3 * DIG_W;
    localparam int unsigned SUM_W   = DIG_W + 1;

    typedef enum logic {PLAY, OVER} state_t;

    state_t               state;
    logic                 eat_d;
    logic                 go_d;
    logic                 hi_pend;
    logic [DIG_W-1:0]     units;
    logic [DIG_W-1:0]     tens;
    logic [DIG_W-1:0]     hund;
    logic [SCORE_W-1:0]   hi;
    logic                 nr;
    logic                 sat;

    logic                 eat_rise_c;
    logic                 go_rise_c;
    logic [SCORE_W-1:0]   score_c;
    logic [SUM_W-1:0]     u_sum_c;
    logic [SUM_W-1:0]     t_sum_c;
    logic [SUM_W-1:0]     h_sum_c;
    logic                 u_carry_c;
    logic                 t_carry_c;
    logic                 h_carry_c;
    logic [DIG_W-1:0]     u_next_c;
    logic [DIG_W-1:0]     t_next_c;
    logic [DIG_W-1:0]     h_next_c;
    logic [SCORE_W-1:0]   sum_c;

    // Edge detect and ripple BCD add; a hundreds carry means the true sum passed 999.
    always_comb begin
        eat_rise_c = bus.eat & ~eat_d;
        go_rise_c  = bus.game_over & ~go_d;
        score_c    = {hund, tens, units};

        u_sum_c    = SUM_W'(units) + SUM_W'(POINTS_PER_EAT);
        u_carry_c  = (u_sum_c > SUM_W'(9));
        u_next_c   = u_carry_c ? DIG_W'(u_sum_c - SUM_W'(10)) : u_sum_c[DIG_W-1:0];

        t_sum_c    = SUM_W'(tens) + SUM_W'(u_carry_c);
        t_carry_c  = (t_sum_c > SUM_W'(9));
        t_next_c   = t_carry_c ? DIG_W'(t_sum_c - SUM_W'(10)) : t_sum_c[DIG_W-1:0];

        h_sum_c    = SUM_W'(hund) + SUM_W'(t_carry_c);
        h_carry_c  = (h_sum_c > SUM_W'(9));
        h_next_c   = h_sum_c[DIG_W-1:0];

        sum_c      = h_carry_c ? SCORE_W'(12'h999) : {h_next_c, t_next_c, u_next_c};
    end

    // PLAY/OVER control, score, high score and record flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= PLAY;
            eat_d   <= 1'b0;
            go_d    <= 1'b0;
            hi_pend <= 1'b0;
            units   <= '0;
            tens    <= '0;
            hund    <= '0;
            hi      <= '0;
            nr      <= 1'b0;
            sat     <= 1'b0;
        end else begin
            eat_d   <= bus.eat;
            go_d    <= bus.game_over;
            hi_pend <= 1'b0;

            // hi_pend is only ever set on entry to OVER, so this is the first OVER cycle.
            if (hi_pend && (score_c > hi)) begin
                hi <= score_c;
            end

            if (bus.restart) begin
                state <= PLAY;
                units <= '0;
                tens  <= '0;
                hund  <= '0;
                sat   <= 1'b0;
                nr    <= 1'b0;
            end else if (state == PLAY) begin
                nr <= (score_c > hi);
                if (eat_rise_c) begin
                    {hund, tens, units} <= sum_c;
                    sat                 <= (sum_c == SCORE_W'(12'h999));
                end
                if (go_rise_c) begin
                    state   <= OVER;
                    hi_pend <= 1'b1;
                end
            end
        end
    end

    assign bus.score_data = units;
    assign bus.score_tens = tens;
    assign bus.score_hund = hund;
    assign bus.hi_score   = hi;
    assign bus.new_record = nr;
    assign bus.saturated  = sat;

endmodule

// File: tb/tb_snake_score_keeper.sv
// Bench for snake_score_keeper: constant vector table, directed carry/saturation/reset
// sequences and random stimulus against an integer-arithmetic model (P = 1 and P = 7).
module tb_snake_score_keeper;

    logic clk;
    logic rst_n;
    logic eat;
    logic game_over;
    logic restart;

    int n_vec;
    int n_err;

    snake_score_if bus1 ();
    snake_score_if bus7 ();

    assign bus1.eat       = eat;
    assign bus1.game_over = game_over;
    assign bus1.restart   = restart;
    assign bus7.eat       = eat;
    assign bus7.game_over = game_over;
    assign bus7.restart   = restart;

    snake_score_keeper #(.POINTS_PER_EAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    snake_score_keeper #(.POINTS_PER_EAT(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers, indexed 0 -> P=1, 1 -> P=7.
    int pts     [2] = '{1, 7};
    int m_score [2];
    int m_hi    [2];
    bit m_nr    [2];
    bit m_sat   [2];
    bit m_over  [2];
    bit m_pend  [2];
    bit m_eat_d;
    bit m_go_d;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [25:0] dut_out(input int i);
        if (i == 0)
            return {bus1.score_hund, bus1.score_tens, bus1.score_data,
                    bus1.hi_score, bus1.new_record, bus1.saturated};
        return {bus7.score_hund, bus7.score_tens, bus7.score_data,
                bus7.hi_score, bus7.new_record, bus7.saturated};
    endfunction

    function automatic logic [25:0] model_out(input int i);
        return {to_bcd(m_score[i]), to_bcd(m_hi[i]), m_nr[i], m_sat[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit er;
        bit gr;
        int s_old;
        int h_old;
        er = eat && !m_eat_d;
        gr = game_over && !m_go_d;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_score[i] = 0; m_hi[i] = 0; m_nr[i] = 0;
                m_sat[i]   = 0; m_over[i] = 0; m_pend[i] = 0;
            end else begin
                s_old = m_score[i];
                h_old = m_hi[i];
                if (m_pend[i] && s_old > h_old) m_hi[i] = s_old;
                m_pend[i] = 0;
                if (restart) begin
                    m_score[i] = 0; m_sat[i] = 0; m_nr[i] = 0; m_over[i] = 0;
                end else if (!m_over[i]) begin
                    m_nr[i] = (s_old > h_old);
                    if (er) begin
                        m_score[i] = (s_old + pts[i] > 999) ? 999 : s_old + pts[i];
                        m_sat[i]   = (m_score[i] == 999);
                    end
                    if (gr) begin
                        m_over[i] = 1;
                        m_pend[i] = 1;
                    end
                end
            end
        end
        m_eat_d = rst_n ? eat : 1'b0;
        m_go_d  = rst_n ? game_over : 1'b0;
    endtask

    // One clock: advance the model with the inputs about to be sampled, then compare both DUTs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("model_p%0d", pts[i]), 32'(dut_out(i)), 32'(model_out(i)));
    endtask

    task automatic pulse_eat(input int n);
        for (int k = 0; k < n; k++) begin
            eat = 1'b1; tick();
            eat = 1'b0; tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; eat = 1'b0; game_over = 1'b0; restart = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit rst_n;
        bit eat;
        bit go;
        bit rs;
        int score;
        int hi;
        bit nr;
        bit sat;
    } vec_t;

    vec_t tbl [28];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; eat = 1'b0; game_over = 1'b0; restart = 1'b0;

        // Expected values for the P=1 instance, one row per clock edge.
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 1, 0, 1, 0};
        tbl[3]  = '{1, 1, 0, 0, 2, 0, 1, 0};
        tbl[4]  = '{1, 1, 0, 0, 2, 0, 1, 0};
        tbl[5]  = '{1, 1, 0, 0, 2, 0, 1, 0};
        tbl[6]  = '{1, 0, 0, 0, 2, 0, 1, 0};
        tbl[7]  = '{1, 0, 1, 0, 2, 0, 1, 0};
        tbl[8]  = '{1, 0, 1, 0, 2, 2, 1, 0};
        tbl[9]  = '{1, 1, 1, 0, 2, 2, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 2, 2, 1, 0};
        tbl[11] = '{1, 0, 0, 1, 0, 2, 0, 0};
        tbl[12] = '{1, 1, 0, 0, 1, 2, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 1, 2, 0, 0};
        tbl[14] = '{1, 1, 0, 0, 2, 2, 0, 0};
        tbl[15] = '{1, 0, 0, 0, 2, 2, 0, 0};
        tbl[16] = '{1, 1, 0, 0, 3, 2, 0, 0};
        tbl[17] = '{1, 0, 0, 0, 3, 2, 1, 0};
        tbl[18] = '{1, 1, 0, 1, 0, 2, 0, 0};
        tbl[19] = '{1, 0, 0, 0, 0, 2, 0, 0};
        tbl[20] = '{1, 0, 1, 1, 0, 2, 0, 0};
        tbl[21] = '{1, 1, 0, 0, 1, 2, 0, 0};
        tbl[22] = '{1, 0, 0, 0, 1, 2, 0, 0};
        tbl[23] = '{1, 1, 0, 0, 2, 2, 0, 0};
        tbl[24] = '{1, 0, 0, 0, 2, 2, 0, 0};
        tbl[25] = '{1, 1, 1, 0, 3, 2, 0, 0};
        tbl[26] = '{1, 0, 0, 0, 3, 3, 0, 0};
        tbl[27] = '{0, 0, 0, 0, 0, 0, 0, 0};

        for (int r = 0; r < 28; r++) begin
            rst_n = tbl[r].rst_n; eat = tbl[r].eat;
            game_over = tbl[r].go; restart = tbl[r].rs;
            tick();
            chk($sformatf("table_row%0d", r), 32'(dut_out(0)),
                32'({to_bcd(tbl[r].score), to_bcd(tbl[r].hi), tbl[r].nr, tbl[r].sat}));
        end

        // Twelve pulses: P=1 steps 1..12, P=7 steps 7, 14, 21, ...
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            eat = 1'b1; tick();
            chk($sformatf("count_p1_%0d", k), 32'(dut_out(0) >> 14), 32'(to_bcd(k)));
            chk($sformatf("count_p7_%0d", k), 32'(dut_out(1) >> 14), 32'(to_bcd(7 * k)));
            eat = 1'b0; tick();
        end
        chk("units_tens_after_12", 32'({bus1.score_tens, bus1.score_data}), 32'(8'h12));

        // Level held for five cycles counts once.
        eat = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        eat = 1'b0; tick();
        chk("held_eat", 32'(dut_out(0) >> 14), 32'(to_bcd(13)));

        // Saturation at 999.
        do_reset();
        pulse_eat(998);
        chk("preload_998", 32'(dut_out(0) >> 14), 32'(to_bcd(998)));
        for (int k = 0; k < 3; k++) begin
            eat = 1'b1; tick();
            chk($sformatf("sat_score_%0d", k), 32'(dut_out(0) >> 14), 32'(to_bcd(999)));
            chk($sformatf("sat_flag_%0d", k), 32'(bus1.saturated), 32'(1));
            eat = 1'b0; tick();
        end

        // Mid-game reset with score 033 and high score 050.
        do_reset();
        pulse_eat(50);
        game_over = 1'b1; tick(); tick();
        game_over = 1'b0;
        chk("hi_050", 32'(bus1.hi_score), 32'(12'h050));
        restart = 1'b1; tick();
        restart = 1'b0;
        pulse_eat(33);
        chk("score_033", 32'(dut_out(0) >> 14), 32'(to_bcd(33)));
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk("midgame_reset", 32'(dut_out(0)), 32'(0));
        eat = 1'b1; tick();
        chk("play_after_reset", 32'(dut_out(0) >> 14), 32'(to_bcd(1)));
        eat = 1'b0; tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            eat       = 1'($urandom_range(0, 1));
            game_over = ($urandom_range(0, 9) == 0);
            restart   = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
